// File: rtl/moore_seq_decoder_pkg.sv
// Shared definitions for the Moore sequence decoder.
// Contents:
//   - State index constants S0..S5 and the INVALID code (3 bits).
//   - Active-low 7-segment glyph constants, {a..g} with a in the MSB.
//   - next_state(): the source Moore FSM transition table.
//   - ACQUIRE/LOCKED encoding of the decoder FSM.
// Optional feature macro used by the top: REPEAT_FILTER_EN.
package moore_seq_decoder_pkg;

    localparam logic [2:0] S0      = 3'd0;
    localparam logic [2:0] S1      = 3'd1;
    localparam logic [2:0] S2      = 3'd2;
    localparam logic [2:0] S3      = 3'd3;
    localparam logic [2:0] S4      = 3'd4;
    localparam logic [2:0] S5      = 3'd5;
    localparam logic [2:0] INVALID = 3'd7;

    localparam logic [6:0] GLYPH_S0 = 7'b0000001;
    localparam logic [6:0] GLYPH_S1 = 7'b1001111;
    localparam logic [6:0] GLYPH_S2 = 7'b0010010;
    localparam logic [6:0] GLYPH_S3 = 7'b0000110;
    localparam logic [6:0] GLYPH_S4 = 7'b1001100;
    localparam logic [6:0] GLYPH_S5 = 7'b0100100;

    localparam logic [0:0] ST_ACQUIRE = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;

    // Transition table of the display FSM whose state walk is being decoded.
    function automatic logic [2:0] next_state(input logic [2:0] prev, input logic in_bit);
        logic [2:0] nxt;
        case (prev)
            S0:      nxt = in_bit ? S3 : S1;
            S1:      nxt = in_bit ? S5 : S2;
            S2:      nxt = in_bit ? S0 : S3;
            S3:      nxt = in_bit ? S1 : S4;
            S4:      nxt = in_bit ? S2 : S5;
            S5:      nxt = in_bit ? S4 : S0;
            default: nxt = INVALID;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/moore_seq_decoder_seg_glyph_decode.sv
// Combinational 7-segment glyph decoder.
// Ports:
//   seg_in [6:0] : active-low segment pattern {a..g}, MSB = a
//   idx    [2:0] : state index S0..S5, INVALID for unknown patterns
//   valid        : 1 when seg_in is one of the six state glyphs
module seg_glyph_decode
    import moore_seq_decoder_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [2:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = INVALID;
        valid = 1'b1;
        case (seg_in)
            GLYPH_S0: idx = S0;
            GLYPH_S1: idx = S1;
            GLYPH_S2: idx = S2;
            GLYPH_S3: idx = S3;
            GLYPH_S4: idx = S4;
            GLYPH_S5: idx = S5;
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/moore_seq_decoder.sv
// Moore sequence decoder: observes the display FSM's 7-segment digit once per
// tick and recovers the serial input bit stream that drove its state walk.
// Recovered bits are packed into WORD_W-bit words (first bit in the MSB) and
// illegal glyphs/transitions are flagged and counted (saturating).
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   tick       : one-clk sample strobe
//   seg_in     : active-low segment pattern {a..g}
//   bit_out    : recovered bit, qualified by bit_valid
//   bit_valid  : one-clk pulse per recovered bit
//   word_out   : last assembled word (held between word_valid pulses)
//   word_valid : one-clk pulse with the final bit of each word
//   locked     : decoder holds a previous state
//   err        : one-clk pulse on illegal glyph or transition
//   err_cnt    : saturating count of err pulses
// Optional feature: define REPEAT_FILTER_EN to treat cur == prev as a hold
// (oversampling) instead of an illegal transition.
module moore_seq_decoder
    import moore_seq_decoder_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [6:0]           seg_in,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [WORD_W-1:0]    word_out,
    output logic                 word_valid,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [2:0]           glyph_idx;
    logic                 glyph_valid;

    logic [0:0]           state_q,   state_d;
    logic [2:0]           prev_q,    prev_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WORD_W-1:0]    shift_q,   shift_d;
    logic [WORD_W-1:0]    word_q,    word_d;
    logic                 bit_q,     bit_d;
    logic                 bv_q,      bv_d;
    logic                 wv_q,      wv_d;
    logic                 err_q,     err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 emit;
    logic                 emit_bit;

    seg_glyph_decode u_glyph (
        .seg_in (seg_in),
        .idx    (glyph_idx),
        .valid  (glyph_valid)
    );

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        word_d   = word_q;
        bit_d    = bit_q;
        bv_d     = 1'b0;
        wv_d     = 1'b0;
        err_d    = 1'b0;
        emit     = 1'b0;
        emit_bit = 1'b0;

        if (tick) begin
            if (state_q == ST_ACQUIRE) begin
                if (glyph_valid) begin
                    prev_d  = glyph_idx;
                    state_d = ST_LOCKED;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (!glyph_valid) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = ST_ACQUIRE;
                end
`ifdef REPEAT_FILTER_EN
                else if (glyph_idx == prev_q) begin
                    // Oversampled repeat of the same digit: hold everything.
                    state_d = state_q;
                end
`endif
                else if (glyph_idx == next_state(prev_q, 1'b0)) begin
                    emit     = 1'b1;
                    emit_bit = 1'b0;
                    prev_d   = glyph_idx;
                end else if (glyph_idx == next_state(prev_q, 1'b1)) begin
                    emit     = 1'b1;
                    emit_bit = 1'b1;
                    prev_d   = glyph_idx;
                end else begin
                    // Valid glyph but no table edge: resync on it, drop the partial word.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                    prev_d  = glyph_idx;
                end
            end

            if (emit) begin
                bit_d   = emit_bit;
                bv_d    = 1'b1;
                shift_d = {shift_q[WORD_W-2:0], emit_bit};
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    cnt_d  = '0;
                    word_d = shift_d;
                    wv_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ACQUIRE;
            prev_q    <= S0;
            cnt_q     <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            bit_q     <= 1'b0;
            bv_q      <= 1'b0;
            wv_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            bv_q      <= bv_d;
            wv_q      <= wv_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bit_out    = bit_q;
    assign bit_valid  = bv_q;
    assign word_out   = word_q;
    assign word_valid = wv_q;
    assign locked     = (state_q == ST_LOCKED);
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule
